// File: rtl/time_pkg.sv
// Shared definitions for the time-of-day core: field codes, counter limits
// and the binary-hour to BCD helper used by the display decode.
package time_pkg;

  typedef enum logic [1:0] {
    FLD_SEC  = 2'd0,
    FLD_MIN  = 2'd1,
    FLD_HOUR = 2'd2
  } field_e;

  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;

  // Returns {tens[1:0], units[3:0]} for a binary hour value 0..23.
  function automatic logic [5:0] hour_to_bcd(input logic [4:0] h);
    logic [1:0] tens;
    logic [3:0] units;
    if (h >= 5'd20) begin
      tens  = 2'd2;
      units = 4'(h - 5'd20);
    end else if (h >= 5'd10) begin
      tens  = 2'd1;
      units = 4'(h - 5'd10);
    end else begin
      tens  = 2'd0;
      units = 4'(h);
    end
    return {tens, units};
  endfunction

endpackage

// File: rtl/bcd_pair_cnt.sv
// Two-digit BCD counter wrapping at TENS_MAX/UNITS_MAX back to 00.
// clr has priority over inc; carry flags the wrapping increment.
module bcd_pair_cnt
  import time_pkg::*;
#(
  parameter int unsigned TENS_W    = 3,
  parameter int unsigned TENS_MAX  = SEC_MAX / 10,
  parameter int unsigned UNITS_MAX = SEC_MAX % 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [TENS_W-1:0] tens,
  output logic [3:0]        units,
  output logic              carry
);

  logic [TENS_W-1:0] tens_q, tens_d;
  logic [3:0]        units_q, units_d;
  logic              at_max;

  assign at_max = (tens_q == TENS_W'(TENS_MAX)) && (units_q == 4'(UNITS_MAX));

  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (clr) begin
      tens_d  = '0;
      units_d = '0;
    end else if (inc) begin
      if (at_max) begin
        tens_d  = '0;
        units_d = '0;
      end else if (units_q == 4'd9) begin
        tens_d  = tens_q + 1'b1;
        units_d = '0;
      end else begin
        units_d = units_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign tens  = tens_q;
  assign units = units_q;
  assign carry = inc & ~clr & at_max;

endmodule

// File: rtl/time_keeper_p.sv
// Time-of-day core: tick prescaler, BCD sec/min, binary hour with 12/24 h
// decode, run/set control with switch edge detect and a day-rollover pulse.
module time_keeper_p
  import time_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TIMESET_RUN,
  input  logic       SW_F1,
  input  logic       SW_F2,
  input  logic       MODE_24H,
  output logic       TIM_AMPM,
  output logic [1:0] TIM_HOURHIGH,
  output logic [3:0] TIM_HOURLOW,
  output logic [2:0] TIM_MINHIGH,
  output logic [3:0] TIM_MINLOW,
  output logic [2:0] TIM_SECHIGH,
  output logic [3:0] TIM_SECLOW,
  output logic [1:0] TIM_FIELD,
  output logic       DAY_TICK
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    hour_q, hour_d;
  field_e        field_q, field_d;
  logic          f1_prev_q, f1_prev_d;
  logic          f2_prev_q, f2_prev_d;
  logic          set_prev_q, set_prev_d;
  logic          day_tick_q, day_tick_d;

  logic run, set_entry, set_act;
  logic f1_edge, f2_edge, tick;
  logic sec_inc, sec_clr, sec_carry;
  logic min_inc, min_carry;
  logic [4:0] disp_hour;
  logic [5:0] hour_bcd;

  // set_prev distinguishes the mode-entry cycle, where switch edges are dropped.
  assign run       = ~TIMESET_RUN;
  assign set_entry = TIMESET_RUN & ~set_prev_q;
  assign set_act   = TIMESET_RUN & set_prev_q;
  assign f1_edge   = SW_F1 & ~f1_prev_q;
  assign f2_edge   = SW_F2 & ~f2_prev_q;
  assign tick      = run & (presc_q == PW'(TICK_DIV - 1));

  assign sec_inc = tick;
  assign sec_clr = set_act & f2_edge & (field_q == FLD_SEC);
  assign min_inc = (run & sec_carry) | (set_act & f2_edge & (field_q == FLD_MIN));

  bcd_pair_cnt #(
    .TENS_W   (3),
    .TENS_MAX (SEC_MAX / 10),
    .UNITS_MAX(SEC_MAX % 10)
  ) u_sec (
    .clk  (CLK),
    .rst_n(RST),
    .inc  (sec_inc),
    .clr  (sec_clr),
    .tens (TIM_SECHIGH),
    .units(TIM_SECLOW),
    .carry(sec_carry)
  );

  bcd_pair_cnt #(
    .TENS_W   (3),
    .TENS_MAX (MIN_MAX / 10),
    .UNITS_MAX(MIN_MAX % 10)
  ) u_min (
    .clk  (CLK),
    .rst_n(RST),
    .inc  (min_inc),
    .clr  (1'b0),
    .tens (TIM_MINHIGH),
    .units(TIM_MINLOW),
    .carry(min_carry)
  );

  always_comb begin
    presc_d    = '0;
    hour_d     = hour_q;
    day_tick_d = 1'b0;
    field_d    = field_q;
    f1_prev_d  = SW_F1;
    f2_prev_d  = SW_F2;
    set_prev_d = TIMESET_RUN;

    if (run) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (min_carry) begin
        if (hour_q == 5'(HOUR_MAX)) begin
          hour_d     = '0;
          day_tick_d = 1'b1;
        end else begin
          hour_d = hour_q + 5'd1;
        end
      end
    end else if (set_act && f2_edge && (field_q == FLD_HOUR)) begin
      hour_d = (hour_q == 5'(HOUR_MAX)) ? '0 : hour_q + 5'd1;
    end

    // F2 has already been applied to the old field above, so advancing here is safe.
    if (set_entry) begin
      field_d = FLD_SEC;
    end else if (set_act && f1_edge) begin
      unique case (field_q)
        FLD_SEC: field_d = FLD_MIN;
        FLD_MIN: field_d = FLD_HOUR;
        default: field_d = FLD_SEC;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc_q    <= '0;
      hour_q     <= '0;
      field_q    <= FLD_SEC;
      f1_prev_q  <= 1'b0;
      f2_prev_q  <= 1'b0;
      set_prev_q <= 1'b0;
      day_tick_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      hour_q     <= hour_d;
      field_q    <= field_d;
      f1_prev_q  <= f1_prev_d;
      f2_prev_q  <= f2_prev_d;
      set_prev_q <= set_prev_d;
      day_tick_q <= day_tick_d;
    end
  end

  always_comb begin
    disp_hour = hour_q;
    if (!MODE_24H) begin
      if (hour_q == 5'd0) begin
        disp_hour = 5'd12;
      end else if (hour_q > 5'd12) begin
        disp_hour = hour_q - 5'd12;
      end
    end
  end

  assign hour_bcd     = hour_to_bcd(disp_hour);
  assign TIM_HOURHIGH = hour_bcd[5:4];
  assign TIM_HOURLOW  = hour_bcd[3:0];
  assign TIM_AMPM     = (hour_q >= 5'd12);
  assign TIM_FIELD    = field_q;
  assign DAY_TICK     = day_tick_q;

endmodule
